// File: rtl/vlan_cfg_pkg.sv
// Shared types for the VLAN configuration commit controller.
// Config entry: {match_pri, match_tag, vid[15:0]} (18 bits).
// CAM entry:    {must_match, vid[15:0]}           (17 bits).
package vlan_cfg_pkg;
  localparam int VID_SIZE        = 16;
  localparam int ET_SIZE         = 16;
  localparam int CFG_REG_WIDTH   = VID_SIZE + 2;
  localparam int CAM_ENTRY_WIDTH = VID_SIZE + 1;

  typedef struct packed {
    logic                match_pri;
    logic                match_tag;
    logic [VID_SIZE-1:0] vid;
  } vlan_cfg_t;

  typedef struct packed {
    logic                must_match;
    logic [VID_SIZE-1:0] vid;
  } vlan_cam_t;

  typedef enum logic {IDLE = 1'b0, WAIT_EOP = 1'b1} state_t;
endpackage

// File: rtl/vlan_pkt_boundary_trk.sv
// Packet boundary tracker: o_in_pkt is high between the first and the last
// beat of a packet (exclusive of the cycle after tlast).
// Ports: clk/rst (async, active-high), i_valid/i_ready/i_last handshake,
//        o_in_pkt flag.
module vlan_pkt_boundary_trk (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  logic i_ready,
  input  logic i_last,
  output logic o_in_pkt
);
  logic r_in_pkt;

  // A non-last beat opens a packet, a last beat closes it; a single-beat
  // packet therefore never sets the flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_in_pkt <= 1'b0;
    else if (i_valid && i_ready) r_in_pkt <= ~i_last;
  end

  assign o_in_pkt = r_in_pkt;
endmodule

// File: rtl/vlan_cfg_commit_ctrl.sv
// VLAN config/CAM table owner. Management writes land in a shadow copy;
// a commit copies shadow to active in one cycle at a packet boundary,
// during which the ingress handshake is held off.
// Ports: aclk/areset, up_* ingress handshake, down_* parser handshake,
//        vlan_config_sel/vlan_config_regs lookup, vlan_cam_values packed CAM,
//        cfg_wr_* shadow write port, cfg_commit/cfg_busy/cfg_done commit
//        control, cfg_wr_err dropped-write pulse.
module vlan_cfg_commit_ctrl
  import vlan_cfg_pkg::*;
#(
  parameter  int AXIS_ID_WIDTH = 4,
  localparam int EFF_ID_WIDTH  = (AXIS_ID_WIDTH > 1) ? AXIS_ID_WIDTH : 1,
  localparam int NUM_AXIS_ID   = 2 ** AXIS_ID_WIDTH
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic                                   up_tvalid,
  output logic                                   up_tready,
  input  logic                                   up_tlast,
  output logic                                   down_tvalid,
  input  logic                                   down_tready,
  input  logic [EFF_ID_WIDTH-1:0]                vlan_config_sel,
  output logic [CFG_REG_WIDTH-1:0]               vlan_config_regs,
  output logic [CAM_ENTRY_WIDTH*NUM_AXIS_ID-1:0] vlan_cam_values,
  input  logic                                   cfg_wr_en,
  input  logic                                   cfg_wr_tbl,
  input  logic [EFF_ID_WIDTH-1:0]                cfg_wr_id,
  input  logic [CFG_REG_WIDTH-1:0]               cfg_wr_data,
  output logic                                   cfg_wr_err,
  input  logic                                   cfg_commit,
  output logic                                   cfg_busy,
  output logic                                   cfg_done
);
  state_t    r_state;
  logic      r_busy, r_done, r_wr_err;
  vlan_cfg_t r_shd_cfg [NUM_AXIS_ID];
  vlan_cfg_t r_act_cfg [NUM_AXIS_ID];
  vlan_cam_t r_shd_cam [NUM_AXIS_ID];
  vlan_cam_t r_act_cam [NUM_AXIS_ID];
  logic      w_in_pkt, w_hold;

  // Hold only depends on registered state, never on up_tvalid, so there is
  // no combinational up_tvalid -> up_tready path.
  assign w_hold      = (r_state == WAIT_EOP) && !w_in_pkt;
  assign up_tready   = down_tready & ~w_hold;
  assign down_tvalid = up_tvalid & ~w_hold;

  vlan_pkt_boundary_trk u_trk (
    .clk      (aclk),
    .rst      (areset),
    .i_valid  (up_tvalid),
    .i_ready  (up_tready),
    .i_last   (up_tlast),
    .o_in_pkt (w_in_pkt)
  );

  // Shadow tables: writable only while no commit is pending.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_AXIS_ID; i++) begin
        r_shd_cfg[i] <= '0;
        r_shd_cam[i] <= '0;
      end
    end else if (cfg_wr_en && (r_state == IDLE)) begin
      if (cfg_wr_tbl) r_shd_cam[cfg_wr_id] <= cfg_wr_data[CAM_ENTRY_WIDTH-1:0];
      else            r_shd_cfg[cfg_wr_id] <= cfg_wr_data;
    end
  end

  // Active tables: whole-table copy on the bubble cycle.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_AXIS_ID; i++) begin
        r_act_cfg[i] <= '0;
        r_act_cam[i] <= '0;
      end
    end else if (w_hold) begin
      for (int i = 0; i < NUM_AXIS_ID; i++) begin
        r_act_cfg[i] <= r_shd_cfg[i];
        r_act_cam[i] <= r_shd_cam[i];
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_done   <= w_hold;
      r_wr_err <= cfg_wr_en && (r_state == WAIT_EOP);
      case (r_state)
        IDLE: if (cfg_commit) begin
          r_state <= WAIT_EOP;
          r_busy  <= 1'b1;
        end
        WAIT_EOP: if (w_hold) begin   // repeated commits here are ignored
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cfg_busy         = r_busy;
  assign cfg_done         = r_done;
  assign cfg_wr_err       = r_wr_err;
  assign vlan_config_regs = r_act_cfg[vlan_config_sel];

  for (genvar j = 0; j < NUM_AXIS_ID; j++) begin : g_cam
    assign vlan_cam_values[CAM_ENTRY_WIDTH*j +: CAM_ENTRY_WIDTH] = r_act_cam[j];
  end
endmodule

// File: doc/vlan_cfg_commit_ctrl.md
Name: vlan_cfg_commit_ctrl

Overview:
Owns the per-ID VLAN configuration and CAM tables consumed by the VLAN parser. Management writes land in a shadow copy. A commit request moves shadow to active atomically, only at an ingress packet boundary, so no packet ever sees mixed configuration. Sits beside the VLAN parser: it serves vlan_config_sel lookups and gates the parser's input handshake during the commit cycle.

Parameters:
AXIS_ID_WIDTH, 4, stream ID width; NUM_AXIS_ID = 2**AXIS_ID_WIDTH entries (derived localparam)
EFF_ID_WIDTH, derived, max(AXIS_ID_WIDTH,1)
CFG_REG_WIDTH, derived = 18, {match_pri, match_tag, vid[15:0]}
CAM_ENTRY_WIDTH, derived = 17, {must_match, vid[15:0]}

Ports:
aclk  in  1  clock
areset  in  1  asynchronous, active-high reset
up_tvalid  in  1  ingress tvalid (from upstream)
up_tready  out  1  ingress tready to upstream = down_tready & ~hold
up_tlast  in  1  ingress tlast
down_tvalid  out  1  tvalid to parser = up_tvalid & ~hold
down_tready  in  1  tready from parser
vlan_config_sel  in  EFF_ID_WIDTH  parser lookup index
vlan_config_regs  out  18  active config of entry vlan_config_sel (combinational)
vlan_cam_values  out  17*NUM_AXIS_ID  packed active CAM; entry j at [17*j +: 17]
cfg_wr_en  in  1  shadow write strobe
cfg_wr_tbl  in  1  0 = config table, 1 = CAM table
cfg_wr_id  in  EFF_ID_WIDTH  entry index
cfg_wr_data  in  18  write data; CAM uses [16:0], bit 17 ignored
cfg_wr_err  out  1  1-cycle pulse: write dropped (busy)
cfg_commit  in  1  commit request pulse
cfg_busy  out  1  commit pending
cfg_done  out  1  1-cycle pulse on the cycle after the active tables update

Behaviour:
- Reset (async, areset=1): all shadow and active entries 0; in_pkt=0; state IDLE.
- Reset outputs: hold=0, cfg_busy=0, cfg_done=0, cfg_wr_err=0.
- Ingress tracking: an ingress beat is up_tvalid & up_tready.
  - in_pkt is set on a beat with up_tlast=0.
  - in_pkt is cleared on a beat with up_tlast=1.
  - A single-beat packet leaves in_pkt at 0.
- States: IDLE, WAIT_EOP.
  - IDLE: cfg_commit=1 -> WAIT_EOP. cfg_busy=1 from the next cycle.
  - WAIT_EOP: hold = ~in_pkt (combinational).
  - When hold=1: active <= shadow (both tables) at that edge; state -> IDLE; cfg_done pulses the following cycle.
  - Because hold forces up_tready=0 and down_tvalid=0 that cycle, no beat transfers while the tables change.
  - A first beat after the commit sees the new configuration.
- Commit latency:
  - Idle link: commit in cycle N, tables update at the edge ending cycle N+1, cfg_done in N+2.
  - Mid-packet: the update happens on the first cycle after the tlast beat.
  - Wait is unbounded if a packet never ends (by design).
- Throughput cost: exactly one bubble cycle per commit.
- Shadow writes:
  - Accepted only when state=IDLE; the write updates the shadow at the edge.
  - cfg_wr_en while busy: write dropped, cfg_wr_err=1 next cycle.
  - cfg_wr_en and cfg_commit in the same IDLE cycle: the write is included in the commit.
- cfg_commit while WAIT_EOP: ignored, no error.
- Lookup: vlan_config_regs = active_cfg[vlan_config_sel], zero latency. vlan_cam_values is driven directly from the active flops.
- hold never depends on up_tvalid. There is no combinational path from up_tvalid to up_tready.
- Reset mid-WAIT_EOP aborts the commit. Shadow is lost; hold deasserts immediately.

Decomposition:
- vlan_cfg_pkg holds:
  - VID_SIZE=16, ET_SIZE=16
  - packed struct vlan_cfg_t {match_pri, match_tag, vid}
  - packed struct vlan_cam_t {must_match, vid}
  - state enum {IDLE, WAIT_EOP}
- One sub-module, vlan_pkt_boundary_trk: in_pkt flag from valid/ready/last. It is reusable by other NMU controllers.

Test Plan:
- Reset, then idle link. Write cfg id 3 = 0x2_0064 (match_pri=1, vid=100), then commit.
  -> hold=1 for one cycle; cfg_done pulses 2 cycles after the commit.
  -> vlan_config_sel=3 returns 0x2_0064; the other entries return 0.
- 8-beat packet in flight; commit issued after beat 2.
  -> cfg_busy=1; all 8 beats pass unchanged with old config.
  -> Bubble on the cycle after tlast, tables update, next packet gets the new values.
- Write CAM id 0 = 0x1_0005 while WAIT_EOP.
  -> cfg_wr_err pulses; a later commit leaves CAM entry 0 = 0.
- Back-to-back single-beat packets, tvalid always 1, with a commit.
  -> Exactly one cycle where down_tvalid=0 and up_tready=0; no beat is lost or duplicated.
- Write and commit in the same cycle (cfg id 15 = 0x0_0FFF).
  -> Active entry 15 = 0x0_0FFF after cfg_done.
- areset asserted mid-WAIT_EOP.
  -> Immediately hold=0 and cfg_busy=0; all entries 0; stream resumes on release.
